// File: rtl/multicycle_ctrl_p.sv
// rtl/multicycle_ctrl_p.sv - RV32I multi-cycle control FSM: strobes, PC control, immediates, traps.
module multicycle_ctrl_p #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          SKIP_MEM    = 1'b1,
  parameter bit          TRAP_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins,
  input  logic            mfc,
  input  logic            br_taken,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      alu_op,
  output logic [1:0]      pc_sel,
  output logic            pc_en,
  output logic            ir_en,
  output logic            rf_wr,
  output logic            a_sel,
  output logic            b_sel,
  output logic [1:0]      y_sel,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ma_sel,
  output logic [1:0]      mem_size,
  output logic            trap,
  output logic [1:0]      trap_cause
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_OR = 5'd2, OP_XOR = 5'd3,
                         OP_AND = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                         OP_PASSB = 5'd8, OP_SLT = 5'd9, OP_SLTU = 5'd10;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      trap_cause_q, trap_cause_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_r, is_i, is_l, is_s, is_sb, is_jalr, is_jal, is_lui, is_auipc, legal, is_mem;
  logic        f7_base, f7_alt;
  logic        waiting, expired;
  logic [31:0] imm32;

  assign opc      = ins[6:0];
  assign f3       = ins[14:12];
  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_l     = (opc == 7'b0000011);
  assign is_s     = (opc == 7'b0100011);
  assign is_sb    = (opc == 7'b1100011);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign legal    = is_r | is_i | is_l | is_s | is_sb | is_jalr | is_jal | is_lui | is_auipc;
  assign is_mem   = is_l | is_s;
  assign f7_base  = (ins[31:25] == 7'b0000000);
  assign f7_alt   = (ins[31:25] == 7'b0100000);

  assign a_sel    = is_auipc | is_jal | is_sb;
  assign b_sel    = is_i | is_l | is_s | is_jalr | is_lui | is_auipc | is_jal;
  assign mem_size = is_mem ? ins[13:12] : 2'b10;

  always_comb begin
    imm32 = '0;
    if (is_i || is_l || is_jalr)  imm32 = {{20{ins[31]}}, ins[31:20]};
    else if (is_s)                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    else if (is_sb)               imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    else if (is_lui || is_auipc)  imm32 = {ins[31:12], 12'b0};
    else if (is_jal)              imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  end
  assign imm = XLEN'($signed(imm32));

  // Unrecognised funct7/funct3 combinations fall back to add.
  always_comb begin
    alu_op = OP_ADD;
    if (is_r || is_i) begin
      case (f3)
        3'b000: alu_op = (is_r && f7_alt) ? OP_SUB : OP_ADD;
        3'b001: alu_op = f7_base ? OP_SLL : OP_ADD;
        3'b010: alu_op = (is_i || f7_base) ? OP_SLT : OP_ADD;
        3'b011: alu_op = (is_i || f7_base) ? OP_SLTU : OP_ADD;
        3'b100: alu_op = (is_i || f7_base) ? OP_XOR : OP_ADD;
        3'b101: alu_op = f7_base ? OP_SRL : (f7_alt ? OP_SRA : OP_ADD);
        3'b110: alu_op = (is_i || f7_base) ? OP_OR : OP_ADD;
        3'b111: alu_op = (is_i || f7_base) ? OP_AND : OP_ADD;
        default: alu_op = OP_ADD;
      endcase
    end else if (is_lui) begin
      alu_op = OP_PASSB;
    end
  end

  assign waiting = (state_q == S_FETCH) || ((state_q == S_MEM) && is_mem);
  assign expired = (MEM_TIMEOUT != 0) && waiting && !mfc && (cnt_q == LIMIT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    trap_cause_d = trap_cause_q;
    pc_en        = 1'b0;
    ir_en        = 1'b0;
    rf_wr        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ma_sel       = 1'b1;
    pc_sel       = 2'b00;
    y_sel        = 2'b00;
    trap         = 1'b0;
    if ((MEM_TIMEOUT != 0) && waiting && !mfc) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (expired) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b01;
        end else begin
          mem_rd = 1'b1;
          if (mfc) begin
            ir_en   = 1'b1;
            pc_en   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else if (TRAP_EN) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_sb) begin
          pc_en   = br_taken;
          pc_sel  = 2'b01;
          state_d = S_FETCH;
        end else if (is_mem || !SKIP_MEM) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_mem) begin
          ma_sel = 1'b0;
          if (expired) begin
            state_d      = S_TRAP;
            trap_cause_d = 2'b01;
          end else begin
            mem_rd = is_l;
            mem_wr = is_s;
            if (mfc) state_d = is_l ? S_WB : S_FETCH;
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_wr   = 1'b1;
        state_d = S_FETCH;
        if (is_l) y_sel = 2'b01;
        else if (is_jal || is_jalr) y_sel = 2'b10;
        if (is_jal) begin
          pc_en  = 1'b1;
          pc_sel = 2'b01;
        end else if (is_jalr) begin
          pc_en  = 1'b1;
          pc_sel = 2'b10;
        end
      end
      S_TRAP: begin
        trap    = 1'b1;
        pc_en   = 1'b1;
        pc_sel  = 2'b11;
        state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      cnt_q        <= '0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign trap_cause = trap_cause_q;
endmodule

// File: tb/tb_multicycle_ctrl_p.sv
// tb/tb_multicycle_ctrl_p.sv - scoreboard bench for multicycle_ctrl_p (default and no-trap/no-skip variants).
module tb_multicycle_ctrl_p;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] LW   = 32'h0040A283;
  localparam logic [31:0] SB   = 32'h00208423;
  localparam logic [31:0] JAL  = 32'hFFDFF0EF;
  localparam logic [31:0] ILL  = 32'h0000007F;

  // {pc_en, ir_en, rf_wr, mem_rd, mem_wr, ma_sel, pc_sel, y_sel, trap}
  localparam logic [10:0] IDLE     = {5'b00000, 1'b1, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] FET_WAIT = {5'b00010, 1'b1, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] FET_DONE = {5'b11010, 1'b1, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] WB_ALU   = {5'b00100, 1'b1, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] WB_LD    = {5'b00100, 1'b1, 2'b00, 2'b01, 1'b0};
  localparam logic [10:0] WB_JAL   = {5'b10100, 1'b1, 2'b01, 2'b10, 1'b0};
  localparam logic [10:0] BR_T     = {5'b10000, 1'b1, 2'b01, 2'b00, 1'b0};
  localparam logic [10:0] BR_N     = {5'b00000, 1'b1, 2'b01, 2'b00, 1'b0};
  localparam logic [10:0] MEM_RD   = {5'b00010, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] MEM_WR   = {5'b00001, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [10:0] TRAPV    = {5'b10000, 1'b1, 2'b11, 2'b00, 1'b1};

  logic        clk, rst, mfc, br_taken;
  logic [31:0] ins;
  logic [31:0] imm, imm_2;
  logic [4:0]  alu_op, alu_op_2;
  logic [1:0]  pc_sel, pc_sel_2, y_sel, y_sel_2, mem_size, mem_size_2, trap_cause, trap_cause_2;
  logic        pc_en, ir_en, rf_wr, a_sel, b_sel, mem_rd, mem_wr, ma_sel, trap;
  logic        pc_en_2, ir_en_2, rf_wr_2, a_sel_2, b_sel_2, mem_rd_2, mem_wr_2, ma_sel_2, trap_2;

  typedef struct {
    logic        rst, mfc, br;
    logic [31:0] ins;
    logic [1:0]  tag;
    logic [6:0]  ops;
    logic [31:0] immv;
    logic [1:0]  cause;
    logic [10:0] exp;
  } ent_t;

  ent_t sb[$];
  int   total, bad;

  multicycle_ctrl_p #(.XLEN(32), .MEM_TIMEOUT(4), .SKIP_MEM(1'b1), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ins(ins), .mfc(mfc), .br_taken(br_taken),
    .imm(imm), .alu_op(alu_op), .pc_sel(pc_sel), .pc_en(pc_en), .ir_en(ir_en),
    .rf_wr(rf_wr), .a_sel(a_sel), .b_sel(b_sel), .y_sel(y_sel), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .ma_sel(ma_sel), .mem_size(mem_size), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_ctrl_p #(.XLEN(32), .MEM_TIMEOUT(0), .SKIP_MEM(1'b0), .TRAP_EN(1'b0)) dut_2 (
    .clk(clk), .rst(rst), .ins(ins), .mfc(mfc), .br_taken(br_taken),
    .imm(imm_2), .alu_op(alu_op_2), .pc_sel(pc_sel_2), .pc_en(pc_en_2), .ir_en(ir_en_2),
    .rf_wr(rf_wr_2), .a_sel(a_sel_2), .b_sel(b_sel_2), .y_sel(y_sel_2), .mem_rd(mem_rd_2),
    .mem_wr(mem_wr_2), .ma_sel(ma_sel_2), .mem_size(mem_size_2), .trap(trap_2), .trap_cause(trap_cause_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] obs1();
    return {pc_en, ir_en, rf_wr, mem_rd, mem_wr, ma_sel, pc_sel, y_sel, trap};
  endfunction

  function automatic logic [10:0] obs2();
    return {pc_en_2, ir_en_2, rf_wr_2, mem_rd_2, mem_wr_2, ma_sel_2, pc_sel_2, y_sel_2, trap_2};
  endfunction

  task automatic push(input logic r, input logic m, input logic b, input logic [31:0] i,
                      input logic [1:0] t, input logic [6:0] o, input logic [31:0] iv,
                      input logic [1:0] c, input logic [10:0] x);
    ent_t e;
    e.rst = r; e.mfc = m; e.br = b; e.ins = i; e.tag = t;
    e.ops = o; e.immv = iv; e.cause = c; e.exp = x;
    sb.push_back(e);
  endtask

  task automatic p(input logic m, input logic [31:0] i, input logic [10:0] x);
    push(1'b0, m, 1'b0, i, 2'd0, 7'd0, 32'd0, 2'd0, x);
  endtask

  task automatic drive_next(output ent_t e);
    e = sb.pop_front();
    @(negedge clk);
    rst = e.rst; mfc = e.mfc; br_taken = e.br; ins = e.ins;
    #1;
  endtask

  task automatic test_reset();
    ent_t e;
    int n = 0;
    push(1'b1, 1'b0, 1'b0, ADD, 2'd2, 7'd0, 32'd0, 2'b00, IDLE);
    p(1'b0, ADD, IDLE);
    p(1'b0, ADD, FET_WAIT);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL reset cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd2) begin
        total++;
        if (trap_cause !== e.cause) begin bad++; $display("FAIL reset cyc%0d trap_cause got=%b want=%b", n, trap_cause, e.cause); end
      end
      n++;
    end
  endtask

  task automatic test_alu_ops();
    ent_t e;
    int n = 0;
    logic [31:0] t_ins [8] = '{32'h402081B3, 32'h4020D1B3, 32'h4030D193, 32'h0020B1B3,
                               32'h0050F193, 32'h123452B7, 32'h00001297, 32'h202081B3};
    logic [6:0]  t_ops [8] = '{{5'd1, 2'b00}, {5'd7, 2'b00}, {5'd7, 2'b01}, {5'd10, 2'b00},
                               {5'd4, 2'b01}, {5'd8, 2'b01}, {5'd0, 2'b11}, {5'd0, 2'b00}};
    logic [31:0] t_imm [8] = '{32'h0, 32'h0, 32'h403, 32'h0, 32'h5, 32'h12345000, 32'h1000, 32'h0};
    p(1'b0, ADD, FET_WAIT);
    p(1'b1, ADD, FET_DONE);
    p(1'b0, ADD, IDLE);
    push(1'b0, 1'b0, 1'b0, ADD, 2'd1, {5'd0, 2'b00}, 32'd0, 2'd0, IDLE);
    p(1'b0, ADD, WB_ALU);
    for (int k = 0; k < 8; k++) begin
      p(1'b1, t_ins[k], FET_DONE);
      p(1'b0, t_ins[k], IDLE);
      push(1'b0, 1'b0, 1'b0, t_ins[k], 2'd1, t_ops[k], t_imm[k], 2'd0, IDLE);
      p(1'b0, t_ins[k], WB_ALU);
    end
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL alu_ops cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd1) begin
        total++;
        if ({alu_op, a_sel, b_sel, imm} !== {e.ops, e.immv}) begin
          bad++; $display("FAIL alu_ops cyc%0d ins=%h op/a/b/imm got=%h want=%h", n, e.ins, {alu_op, a_sel, b_sel, imm}, {e.ops, e.immv});
        end
      end
      n++;
    end
  endtask

  task automatic test_branch();
    ent_t e;
    int n = 0;
    p(1'b1, BEQ, FET_DONE);
    p(1'b0, BEQ, IDLE);
    push(1'b0, 1'b0, 1'b1, BEQ, 2'd1, {5'd0, 2'b10}, 32'd8, 2'd0, BR_T);
    p(1'b1, BEQ, FET_DONE);
    p(1'b0, BEQ, IDLE);
    push(1'b0, 1'b0, 1'b0, BEQ, 2'd1, {5'd0, 2'b10}, 32'd8, 2'd0, BR_N);
    p(1'b1, BEQ, FET_DONE);
    p(1'b0, BEQ, IDLE);
    push(1'b0, 1'b0, 1'b0, BEQ, 2'd0, 7'd0, 32'd0, 2'd0, BR_N);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL branch cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd1) begin
        total++;
        if ({alu_op, a_sel, b_sel, imm} !== {e.ops, e.immv}) begin
          bad++; $display("FAIL branch cyc%0d op/a/b/imm got=%h want=%h", n, {alu_op, a_sel, b_sel, imm}, {e.ops, e.immv});
        end
      end
      n++;
    end
  endtask

  task automatic test_load_store();
    ent_t e;
    int n = 0;
    p(1'b1, LW, FET_DONE);
    p(1'b0, LW, IDLE);
    push(1'b0, 1'b0, 1'b0, LW, 2'd1, {5'd0, 2'b01}, 32'd4, 2'd0, IDLE);
    for (int k = 0; k < 3; k++) p(1'b0, LW, MEM_RD);
    p(1'b1, LW, MEM_RD);
    p(1'b0, LW, WB_LD);
    p(1'b1, SB, FET_DONE);
    p(1'b0, SB, IDLE);
    push(1'b0, 1'b0, 1'b0, SB, 2'd1, {5'd0, 2'b01}, 32'd8, 2'd0, IDLE);
    p(1'b1, SB, MEM_WR);
    p(1'b0, SB, FET_WAIT);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL load_store cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd1) begin
        total++;
        if ({alu_op, a_sel, b_sel, imm} !== {e.ops, e.immv}) begin
          bad++; $display("FAIL load_store cyc%0d op/a/b/imm got=%h want=%h", n, {alu_op, a_sel, b_sel, imm}, {e.ops, e.immv});
        end
      end
      n++;
    end
    total++;
    if (mem_size !== 2'b00) begin bad++; $display("FAIL load_store mem_size got=%b want=00", mem_size); end
  endtask

  task automatic test_timeout();
    ent_t e;
    int n = 0;
    push(1'b1, 1'b0, 1'b0, ADD, 2'd0, 7'd0, 32'd0, 2'd0, FET_WAIT);
    p(1'b0, ADD, IDLE);
    for (int k = 0; k < 3; k++) p(1'b0, ADD, FET_WAIT);
    p(1'b0, ADD, IDLE);
    push(1'b0, 1'b0, 1'b0, ADD, 2'd2, 7'd0, 32'd0, 2'b01, TRAPV);
    for (int k = 0; k < 3; k++) p(1'b0, ADD, FET_WAIT);
    p(1'b1, ADD, FET_DONE);
    p(1'b0, ADD, IDLE);
    p(1'b0, ADD, IDLE);
    p(1'b0, ADD, WB_ALU);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL timeout cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd2) begin
        total++;
        if (trap_cause !== e.cause) begin bad++; $display("FAIL timeout cyc%0d trap_cause got=%b want=%b", n, trap_cause, e.cause); end
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    int n = 0;
    p(1'b1, ILL, FET_DONE);
    p(1'b0, ILL, IDLE);
    push(1'b0, 1'b0, 1'b0, ILL, 2'd2, 7'd0, 32'd0, 2'b10, TRAPV);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL illegal cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd2) begin
        total++;
        if (trap_cause !== e.cause) begin bad++; $display("FAIL illegal cyc%0d trap_cause got=%b want=%b", n, trap_cause, e.cause); end
      end
      n++;
    end
    total++;
    if (imm !== 32'd0) begin bad++; $display("FAIL illegal imm got=%h want=00000000", imm); end
  endtask

  task automatic test_jal_reset();
    ent_t e;
    int n = 0;
    p(1'b1, JAL, FET_DONE);
    p(1'b0, JAL, IDLE);
    push(1'b0, 1'b0, 1'b0, JAL, 2'd1, {5'd0, 2'b11}, 32'hFFFFFFFC, 2'd0, IDLE);
    p(1'b0, JAL, WB_JAL);
    p(1'b1, SB, FET_DONE);
    p(1'b0, SB, IDLE);
    p(1'b0, SB, IDLE);
    p(1'b0, SB, MEM_WR);
    push(1'b1, 1'b0, 1'b0, SB, 2'd2, 7'd0, 32'd0, 2'b10, MEM_WR);
    push(1'b0, 1'b0, 1'b0, SB, 2'd2, 7'd0, 32'd0, 2'b00, IDLE);
    for (int k = 0; k < 3; k++) p(1'b0, SB, FET_WAIT);
    p(1'b0, SB, IDLE);
    push(1'b0, 1'b0, 1'b0, SB, 2'd2, 7'd0, 32'd0, 2'b01, TRAPV);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs1() !== e.exp) begin bad++; $display("FAIL jal_reset cyc%0d strobes got=%b want=%b", n, obs1(), e.exp); end
      if (e.tag == 2'd1) begin
        total++;
        if ({alu_op, a_sel, b_sel, imm} !== {e.ops, e.immv}) begin
          bad++; $display("FAIL jal_reset cyc%0d op/a/b/imm got=%h want=%h", n, {alu_op, a_sel, b_sel, imm}, {e.ops, e.immv});
        end
      end
      if (e.tag == 2'd2) begin
        total++;
        if (trap_cause !== e.cause) begin bad++; $display("FAIL jal_reset cyc%0d trap_cause got=%b want=%b", n, trap_cause, e.cause); end
      end
      n++;
    end
  endtask

  task automatic test_variant();
    ent_t e;
    int n = 0;
    @(negedge clk); rst = 1'b1; mfc = 1'b0;
    @(negedge clk);
    push(1'b0, 1'b0, 1'b0, ILL, 2'd2, 7'd0, 32'd0, 2'b00, IDLE);
    p(1'b1, ILL, FET_DONE);
    p(1'b0, ILL, IDLE);
    for (int k = 0; k < 20; k++) p(1'b0, ILL, FET_WAIT);
    p(1'b1, ADD, FET_DONE);
    p(1'b0, ADD, IDLE);
    push(1'b0, 1'b0, 1'b0, ADD, 2'd1, {5'd0, 2'b00}, 32'd0, 2'd0, IDLE);
    p(1'b0, ADD, IDLE);
    p(1'b0, ADD, WB_ALU);
    push(1'b0, 1'b0, 1'b0, ADD, 2'd2, 7'd0, 32'd0, 2'b00, FET_WAIT);
    while (sb.size() > 0) begin
      drive_next(e);
      total++;
      if (obs2() !== e.exp) begin bad++; $display("FAIL variant cyc%0d strobes got=%b want=%b", n, obs2(), e.exp); end
      if (e.tag == 2'd1) begin
        total++;
        if ({alu_op_2, a_sel_2, b_sel_2, imm_2} !== {e.ops, e.immv}) begin
          bad++; $display("FAIL variant cyc%0d op/a/b/imm got=%h want=%h", n, {alu_op_2, a_sel_2, b_sel_2, imm_2}, {e.ops, e.immv});
        end
      end
      if (e.tag == 2'd2) begin
        total++;
        if (trap_cause_2 !== e.cause) begin bad++; $display("FAIL variant cyc%0d trap_cause got=%b want=%b", n, trap_cause_2, e.cause); end
      end
      n++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    mfc = 1'b0;
    br_taken = 1'b0;
    ins = ADD;
    repeat (2) @(negedge clk);
    test_reset();
    test_alu_ops();
    test_branch();
    test_load_store();
    test_timeout();
    test_illegal();
    test_jal_reset();
    test_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
